fifo2_bit_loader: RTL
=====================

Name: fifo2_bit_loader

Overview:
- Upstream feeder for the 1-bit, 4-entry serial FIFO (fifo2).
- Accepts parallel words over a valid/ready handshake and drives the FIFO's push, I and clear inputs, one bit per clock.
- The FIFO has no full/empty flags, so this block keeps a mirror of the FIFO occupancy. It updates the mirror from its own pushes and from the downstream pop strobe, which it monitors.
- It never overflows the FIFO. It also flags pops that the consumer issues on an empty FIFO.

Parameters:
- WORD_W, 4: bits per input word; must be >= 1.
- DEPTH, 4: FIFO entry count; must match the FIFO instance.
- MSB_FIRST, 1: 1 = push in_data[WORD_W-1] first; 0 = push in_data[0] first.
- LW, $clog2(DEPTH+1): width of the level output (3 at DEPTH=4). Derived; not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data holds a word to load.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  word to serialise.
- flush  in  1  single-cycle request: abort the current word and empty the FIFO.
- pop_mon  in  1  copy of the pop strobe that the consumer drives into the FIFO.
- err_clr  in  1  clears underflow_err.
- push  out  1  to the FIFO push input.
- I  out  1  to the FIFO data input; valid when push=1.
- clear  out  1  to the FIFO clear input.
- level  out  LW  mirrored FIFO occupancy, 0..DEPTH.
- busy  out  1  state is not IDLE.
- underflow_err  out  1  sticky: a pop was seen while level was 0.

Behaviour:
- States: FLUSH, IDLE, SHIFT.
- Asynchronous reset (rst_n=0) forces:
  - state=FLUSH, level=0, bit counter=0, shift register=0, underflow_err=0.
  - Outputs during reset: clear=1, push=0, in_ready=0, busy=1.
- FLUSH:
  - clear=1, push=0, in_ready=0.
  - Lasts exactly one clock edge. At that edge level<=0, then go to IDLE.
  - After reset release, the first edge therefore clears the FIFO, which has no reset of its own.
- IDLE:
  - in_ready=1, push=0.
  - On in_valid=1 at an edge: load in_data into the shift register, set bit counter=WORD_W, go to SHIFT.
  - flush=1 has priority over in_valid: the word is not accepted, go to FLUSH.
- SHIFT:
  - in_ready=0.
  - I is the current head bit of the shift register (MSB or LSB per MSB_FIRST).
  - push is combinational: push = (level<DEPTH) or (pop_mon=1 and level>0). A same-cycle pop frees a slot because the FIFO pops before it pushes.
  - On a push edge: shift by one bit and decrement the counter. When the counter reaches 0, go to IDLE.
  - Throughput is WORD_W+1 cycles per word when the FIFO is not stalled.
  - flush=1 in SHIFT: push is forced to 0 in that cycle, remaining bits are discarded, go to FLUSH.
- Level update at every edge outside FLUSH and reset:
  - pop_eff = pop_mon and level>0.
  - level <= level + push - pop_eff.
  - Simultaneous push and pop_eff leave level unchanged.
  - level never exceeds DEPTH and never goes below 0.
- Underflow:
  - pop_mon=1 with level=0 sets underflow_err at that edge.
  - In that cycle push is suppressed even if level<DEPTH. A push combined with a pop on an empty FIFO is illegal on the FIFO.
  - underflow_err stays set until err_clr=1. If set and err_clr coincide, set wins.
- pop_mon during FLUSH: the FIFO pops before it clears, so the result is still empty. level<=0 and underflow_err is not set.
- busy = (state != IDLE).
- Reset asserted mid-SHIFT: the word is lost, and after release the FLUSH cycle re-synchronises the FIFO.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles.
   - During reset: clear=1, push=0, in_ready=0, level=0.
   - After release: clear=1 for exactly one edge, then in_ready=1 and clear=0.
2. Load, no pops: in_data=4'b1011, MSB_FIRST=1.
   - push=1 on 4 consecutive cycles with I=1,0,1,1; level=1,2,3,4.
   - busy drops and in_ready=1 on the following cycle.
3. Full stall: level=4, load 4'b0110.
   - push=0 and busy=1 for 5 idle cycles with level held at 4.
   - pop_mon=1 for one cycle: push=1 with I=0 that cycle, level stays 4.
4. Empty pop: level=0 in IDLE, pop_mon=1.
   - level stays 0 and underflow_err=1.
   - underflow_err persists 10 cycles, then err_clr=1 clears it.
   - pop_mon=1 on level=0 during SHIFT: push=0 that cycle.
5. Flush mid-word: after 2 of 4 bits are pushed (level=2), flush=1.
   - push=0 that cycle, clear=1 the next cycle, then level=0.
   - in_ready=1 after; the remaining 2 bits are never pushed.
6. Async reset mid-SHIFT after 1 bit: rst_n=0 between edges.
   - push=0 and clear=1 immediately, with no clock edge needed.
   - After release, one FLUSH cycle, then IDLE with level=0.

Source files
------------

// File: rtl/fifo2_bit_loader.sv
// Serialises parallel words into the 1-bit fifo2 FIFO, one bit per clock, while
// mirroring the FIFO occupancy from its own pushes and the monitored pop strobe.
module fifo2_bit_loader #(
    parameter int WORD_W    = 4,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              flush,
    input  logic              pop_mon,
    input  logic              err_clr,
    output logic              push,
    output logic              I,
    output logic              clear,
    output logic [LW-1:0]     level,
    output logic              busy,
    output logic              underflow_err
);

    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_SHIFT} state_t;

    state_t            state_reg;
    logic [LW-1:0]     level_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WORD_W-1:0] shreg_reg;
    logic              err_reg;

    logic              pop_eff;
    logic              pop_empty;
    logic              room;
    logic [WORD_W-1:0] shreg_next;

    assign pop_eff   = pop_mon && (level_reg != '0);
    assign pop_empty = pop_mon && (level_reg == '0);
    // A pop in the same cycle frees a slot: the FIFO pops before it pushes.
    assign room      = (level_reg < LW'(DEPTH)) || pop_eff;

    assign push          = (state_reg == ST_SHIFT) && !flush && room && !pop_empty;
    assign clear         = (state_reg == ST_FLUSH);
    assign in_ready      = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign level         = level_reg;
    assign underflow_err = err_reg;

    generate
        if (MSB_FIRST) begin : g_msb
            assign I          = shreg_reg[WORD_W-1];
            assign shreg_next = shreg_reg << 1;
        end else begin : g_lsb
            assign I          = shreg_reg[0];
            assign shreg_next = shreg_reg >> 1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FLUSH;
            level_reg <= '0;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_FLUSH) begin
                level_reg <= '0;
            end else if (push && !pop_eff) begin
                level_reg <= level_reg + LW'(1);
            end else if (!push && pop_eff) begin
                level_reg <= level_reg - LW'(1);
            end

            // During FLUSH a pop on the empty FIFO is harmless and not flagged.
            if (pop_empty && state_reg != ST_FLUSH) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                ST_FLUSH: begin
                    state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush) begin
                        state_reg <= ST_FLUSH;
                    end else if (in_valid) begin
                        shreg_reg <= in_data;
                        cnt_reg   <= CW'(WORD_W);
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (flush) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_FLUSH;
                    end else if (push) begin
                        shreg_reg <= shreg_next;
                        cnt_reg   <= cnt_reg - CW'(1);
                        if (cnt_reg == CW'(1)) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_FLUSH;
                end
            endcase
        end
    end

endmodule
